// File: rtl/wallace_mult_sched_pkg.sv
// Shared constants and state encoding for the shared-multiplier scheduler.
//   MULT_W : operand width of the shared multiplier
//   PROD_W : full product width
//   state_t: scheduler FSM states
package wallace_mult_sched_pkg;

    localparam int MULT_W = 32;
    localparam int PROD_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wallace_mult_sched_arb.sv
// Round-robin arbiter, purely combinational.
//   req_i     : request vector
//   ptr_i     : index of the last winner; the search starts just after it
//   gnt_o     : one-hot grant (all zeros when nothing requests)
//   gnt_idx_o : binary index of the granted requester
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_idx_o
);

    logic           found;
    logic [IDW-1:0] cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        // Offsets 1..NREQ visit every requester once, ending on ptr_i itself.
        for (int off = 1; off <= NREQ; off++) begin
            cand = IDW'((int'(ptr_i) + off) % NREQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/wallace_mult_sched_tree.sv
// Combinational unsigned Wallace-tree multiplier.
//   a_i, b_i : MULT_W-bit unsigned operands
//   prod_o   : PROD_W-bit exact product
// Partial-product rows are reduced with layers of 3:2 carry-save compressors
// until two rows remain, then a single carry-propagate add finishes the job.
module wallace_tree
    import wallace_mult_sched_pkg::*;
(
    input  logic [MULT_W-1:0] a_i,
    input  logic [MULT_W-1:0] b_i,
    output logic [PROD_W-1:0] prod_o
);

    localparam int RW         = $clog2(MULT_W);
    // 32 rows shrink 32->22->15->10->7->5->4->3->2 in eight layers.
    localparam int RED_LEVELS = 8;

    logic [PROD_W-1:0] rows [MULT_W];
    logic [PROD_W-1:0] nxt  [MULT_W];
    logic [PROD_W-1:0] x, y, z;
    int                n, m;

    always_comb begin
        x = '0;
        y = '0;
        z = '0;
        n = MULT_W;
        m = 0;
        for (int i = 0; i < MULT_W; i++) begin
            // Zero-extend the multiplicand into a full-width row before shifting.
            rows[RW'(i)] = b_i[RW'(i)] ? (PROD_W'(a_i) << i) : '0;
            nxt[RW'(i)]  = '0;
        end
        for (int lvl = 0; lvl < RED_LEVELS; lvl++) begin
            m = 0;
            for (int k = 0; k < MULT_W; k++) begin
                nxt[RW'(k)] = '0;
            end
            for (int k = 0; k < MULT_W / 3; k++) begin
                if (3 * k + 2 < n) begin
                    x = rows[RW'(3 * k)];
                    y = rows[RW'(3 * k + 1)];
                    z = rows[RW'(3 * k + 2)];
                    nxt[RW'(m)]     = x ^ y ^ z;
                    // Carry out of bit 63 is dropped: the product fits in 64 bits.
                    nxt[RW'(m + 1)] = ((x & y) | (x & z) | (y & z)) << 1;
                    m = m + 2;
                end
            end
            // Rows that do not form a full triple pass straight to the next layer.
            for (int k = 0; k < MULT_W; k++) begin
                if (k >= (n / 3) * 3 && k < n) begin
                    nxt[RW'(m)] = rows[RW'(k)];
                    m = m + 1;
                end
            end
            for (int k = 0; k < MULT_W; k++) begin
                rows[RW'(k)] = nxt[RW'(k)];
            end
            n = m;
        end
        prod_o = rows[0] + rows[1];
    end

endmodule

// File: rtl/wallace_mult_sched.sv
// Shares one combinational 32x32 Wallace multiplier among NREQ requesters.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   req_valid  : per-requester operand valid
//   req_ready  : one-hot combinational grant
//   req_a/b    : packed operands, requester i on [32*i +: 32]
//   resp_valid : registered product-available flag
//   resp_ready : consumer accepts the product
//   resp_id    : requester that owns resp_prod
//   resp_prod  : full 64-bit product
//   busy       : high whenever the scheduler is not idle
// One multiply is in flight at a time. Operands are registered in front of
// the multiplier and the tree is given LAT cycles to settle before capture.
module wallace_mult_sched
    import wallace_mult_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*MULT_W-1:0] req_a,
    input  logic [NREQ*MULT_W-1:0] req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic [PROD_W-1:0]      resp_prod,
    output logic                   busy
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    state_t              state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [MULT_W-1:0]   op_a_q, op_a_d;
    logic [MULT_W-1:0]   op_b_q, op_b_d;
    logic [IDW-1:0]      tag_q, tag_d;
    logic                resp_valid_q, resp_valid_d;
    logic [IDW-1:0]      resp_id_q, resp_id_d;
    logic [PROD_W-1:0]   resp_prod_q, resp_prod_d;
    logic                busy_q;

    logic [NREQ-1:0]     arb_gnt;
    logic [IDW-1:0]      arb_idx;
    logic                grant_win;
    logic                take;
    logic [PROD_W-1:0]   mult_out;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i     (req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    wallace_tree u_mult (
        .a_i    (op_a_q),
        .b_i    (op_b_q),
        .prod_o (mult_out)
    );

    // A new request may be taken when idle, or when the held response is
    // retiring this very cycle.
    assign grant_win = (state_q == ST_IDLE) || ((state_q == ST_DONE) && resp_ready);
    assign req_ready = grant_win ? arb_gnt : '0;
    assign take      = |req_ready;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        tag_d        = tag_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_prod_d  = resp_prod_q;

        case (state_q)
            ST_IDLE: ;
            ST_CALC: begin
                if (cnt_q == '0) begin
                    resp_prod_d  = mult_out;
                    resp_id_d    = tag_q;
                    resp_valid_d = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Grant overrides the IDLE/DONE outcome above.
        if (take) begin
            op_a_d   = req_a[int'(arb_idx) * MULT_W +: MULT_W];
            op_b_d   = req_b[int'(arb_idx) * MULT_W +: MULT_W];
            tag_d    = arb_idx;
            rr_ptr_d = arb_idx;
            cnt_d    = CW'(LAT - 1);
            state_d  = ST_CALC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= IDW'(NREQ - 1);
            cnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            tag_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_prod_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            tag_q        <= tag_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_prod_q  <= resp_prod_d;
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_prod  = resp_prod_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_wallace_mult_sched.sv
module tb_wallace_mult_sched;

    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a = '0;
    logic [NREQ*32-1:0]   req_b = '0;
    logic                 resp_valid;
    logic                 resp_ready = 1'b0;
    logic [IDW-1:0]       resp_id;
    logic [63:0]          resp_prod;
    logic                 busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          id;
        logic [63:0] prod;
        int          cyc;
    } ev_t;
    ev_t glog[$];
    ev_t rlog[$];

    // Behavioural model: a job accepted in cycle c becomes visible in cycle c+LAT+1.
    bit          m_pend;
    bit          m_oval;
    int          m_due;
    int          m_pid;
    int          m_oid;
    int          m_last;
    logic [63:0] m_pprod;
    logic [63:0] m_oprod;

    wallace_mult_sched #(
        .NREQ (NREQ),
        .LAT  (LAT),
        .IDW  (IDW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_prod  (resp_prod),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for the DUT (cycle %0d)", name, cyc);
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = NREQ - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    always @(negedge clk) begin
        int              exp_w;
        logic [NREQ-1:0] exp_rdy;
        logic [IDW-1:0]  k;
        logic [63:0]     pa, pb;
        ev_t             e;
        if (rst) begin
            m_pend = 1'b0;
            m_oval = 1'b0;
            m_last = NREQ - 1;
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_resp_valid", 64'(resp_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
        end else begin
            if (m_pend && cyc == m_due) begin
                m_oval  = 1'b1;
                m_oid   = m_pid;
                m_oprod = m_pprod;
                m_pend  = 1'b0;
            end
            exp_w   = -1;
            exp_rdy = '0;
            if (!m_pend && (!m_oval || resp_ready)) begin
                for (int off = 1; off <= NREQ; off++) begin
                    k = IDW'((m_last + off) % NREQ);
                    if (exp_w < 0 && req_valid[k]) exp_w = int'(k);
                end
            end
            if (exp_w >= 0) exp_rdy[IDW'(exp_w)] = 1'b1;
            chk("model_req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("model_resp_valid", 64'(resp_valid), 64'(m_oval));
            chk("model_busy", 64'(busy), 64'(m_pend || m_oval));
            if (m_oval) begin
                chk("model_resp_id", 64'(resp_id), 64'(m_oid));
                chk("model_resp_prod", resp_prod, m_oprod);
            end
            if (resp_valid && resp_ready) begin
                e.id = int'(resp_id); e.prod = resp_prod; e.cyc = cyc;
                rlog.push_back(e);
            end
            if (req_ready != '0) begin
                e.id = onehot_idx(req_ready); e.prod = '0; e.cyc = cyc;
                glog.push_back(e);
            end
            if (m_oval && resp_ready) m_oval = 1'b0;
            if (exp_w >= 0) begin
                pa      = {32'd0, req_a[32*exp_w +: 32]};
                pb      = {32'd0, req_b[32*exp_w +: 32]};
                m_pend  = 1'b1;
                m_due   = cyc + LAT + 1;
                m_pid   = exp_w;
                m_pprod = pa * pb;
                m_last  = exp_w;
            end
        end
    end

    task automatic wait_grant(input int i, input string name, output int gc);
        bit got;
        got = 1'b0;
        gc  = -1;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                got = 1'b1;
                gc  = cyc;
            end
        end
        if (!got) timeout(name);
    endtask

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input string name);
        int gc;
        req_valid[i]       = 1'b1;
        req_a[32*i +: 32]  = a;
        req_b[32*i +: 32]  = b;
        wait_grant(i, name, gc);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input string name);
        for (int t = 0; t < 40 && rlog.size() < n; t++) @(posedge clk);
        #1;
        if (rlog.size() < n) timeout(name);
    endtask

    task automatic wait_idle(input string name);
        bit idle;
        idle = 1'b0;
        for (int t = 0; t < 40 && !idle; t++) begin
            @(posedge clk); #1;
            if (!busy && !resp_valid) idle = 1'b1;
        end
        if (!idle) timeout(name);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int cnt, g1, g2;
        bit seen;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        chk("reset_resp_id", 64'(resp_id), 64'd0);
        chk("reset_resp_prod", resp_prod, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        // Single request, latency
        resp_ready = 1'b1;
        glog.delete(); rlog.delete();
        issue(0, 32'd3, 32'd5, "t1_grant");
        wait_rsp(1, "t1_resp");
        if (rlog.size() >= 1 && glog.size() >= 1) begin
            chk("t1_grant_id", 64'(glog[0].id), 64'd0);
            chk("t1_prod", rlog[0].prod, 64'd15);
            chk("t1_id", 64'(rlog[0].id), 64'd0);
            chk("t1_latency", 64'(rlog[0].cyc - glog[0].cyc), 64'd3);
        end
        wait_idle("t1_idle");

        // Extremes
        rlog.delete();
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t2_max_grant");
        wait_rsp(1, "t2_max_resp");
        issue(1, 32'h0, 32'h1234_5678, "t2_zero_grant");
        wait_rsp(2, "t2_zero_resp");
        if (rlog.size() >= 2) begin
            chk("t2_max_prod", rlog[0].prod, 64'hFFFF_FFFE_0000_0001);
            chk("t2_zero_prod", rlog[1].prod, 64'd0);
            chk("t2_zero_id", 64'(rlog[1].id), 64'd1);
        end
        wait_idle("t2_idle");

        // Fairness from a fresh reset
        pulse_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = 32'(i + 1);
            req_b[32*i +: 32] = 32'(i + 2);
        end
        req_valid = '1;
        cnt = 0;
        for (int t = 0; t < 60 && cnt < 8; t++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                chk("t3_onehot", 64'($countones(req_ready)), 64'd1);
                chk("t3_order", 64'(onehot_idx(req_ready)), 64'(exp_order[cnt]));
                cnt++;
            end
        end
        if (cnt < 8) timeout("t3_grants");
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle("t3_idle");

        // Backpressure
        resp_ready = 1'b0;
        rlog.delete();
        issue(0, 32'd11, 32'd13, "t4_grant0");
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        if (!seen) timeout("t4_resp_valid");
        @(posedge clk); #1;
        req_valid[1]  = 1'b1;
        req_a[63:32]  = 32'd6;
        req_b[63:32]  = 32'd7;
        repeat (5) begin
            @(negedge clk);
            chk("t4_hold_valid", 64'(resp_valid), 64'd1);
            chk("t4_hold_prod", resp_prod, 64'd143);
            chk("t4_hold_id", 64'(resp_id), 64'd0);
            chk("t4_hold_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("t4_release_grant", 64'(req_ready), 64'h2);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_rsp(2, "t4_resp");
        if (rlog.size() >= 2) begin
            chk("t4_first_prod", rlog[0].prod, 64'd143);
            chk("t4_second_prod", rlog[1].prod, 64'd42);
            chk("t4_second_id", 64'(rlog[1].id), 64'd1);
        end
        wait_idle("t4_idle");

        // Back-to-back from one requester
        rlog.delete();
        resp_ready   = 1'b1;
        req_valid[2] = 1'b1;
        req_a[95:64] = 32'd7;
        req_b[95:64] = 32'd9;
        wait_grant(2, "t5_grant1", g1);
        @(posedge clk); #1;
        req_a[95:64] = 32'd10;
        req_b[95:64] = 32'd10;
        wait_grant(2, "t5_grant2", g2);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        chk("t5_spacing", 64'(g2 - g1), 64'd3);
        wait_rsp(2, "t5_resp");
        if (rlog.size() >= 2) begin
            chk("t5_prod0", rlog[0].prod, 64'd63);
            chk("t5_prod1", rlog[1].prod, 64'd100);
            chk("t5_id0", 64'(rlog[0].id), 64'd2);
            chk("t5_id1", 64'(rlog[1].id), 64'd2);
        end
        wait_idle("t5_idle");

        // Reset during a multiply
        rlog.delete();
        issue(3, 32'd100, 32'd200, "t6_grant");
        #2;
        rst = 1'b1;
        #1;
        chk("t6_req_ready", 64'(req_ready), 64'd0);
        chk("t6_resp_valid", 64'(resp_valid), 64'd0);
        chk("t6_resp_id", 64'(resp_id), 64'd0);
        chk("t6_resp_prod", resp_prod, 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t6_no_resp", 64'(rlog.size()), 64'd0);
        chk("t6_idle_busy", 64'(busy), 64'd0);
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = 32'd2;
            req_b[32*i +: 32] = 32'd3;
        end
        req_valid = '1;
        @(negedge clk);
        chk("t6_first_grant", 64'(req_ready), 64'h1);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle("t6_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
